// File: rtl/dnot_rail_checker.sv
// dnot_rail_checker: recovers one bit from two inverted redundant rails and flags persistent disagreement
module dnot_rail_checker #(
    parameter int STABLE_CYCLES = 4,
    parameter int FAULT_CYCLES  = 8,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rail_a,
    input  logic             rail_b,
    input  logic             clr,
    output logic             data_out,
    output logic             valid,
    output logic             changed,
    output logic             fault,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int DW = $clog2(FAULT_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [DW-1:0] DIS_MAX  = DW'(FAULT_CYCLES);
    typedef enum logic [1:0] {ACQ, TRACK, DISAGREE, FAULT} state_t;
    state_t        r_state, w_state_nx;
    logic          r_a1, r_b1, r_sa, r_sb, r_cand;
    logic [SW-1:0] r_stab, w_stab_nx;
    logic [DW-1:0] r_dis, w_dis_nx;
    logic          w_agree, w_live, w_commit, w_episode;

    // stability run, commit detection and next state from the synchronized samples
    always_comb begin
        w_agree    = r_sa == r_sb;
        w_live     = r_state != FAULT;
        w_stab_nx  = !w_agree ? '0 : (r_sa != r_cand) ? SW'(1) : (r_stab == STAB_MAX) ? r_stab : r_stab + SW'(1);
        w_commit   = w_live && w_agree && w_stab_nx == STAB_MAX && !(r_sa == r_cand && r_stab == STAB_MAX);
        w_episode  = r_state == TRACK && !w_agree;
        w_dis_nx   = (r_state == TRACK) ? DW'(1) : r_dis + DW'(1);
        w_state_nx = r_state;
        if (r_state == ACQ)
            w_state_nx = w_commit ? TRACK : ACQ;
        else if (r_state == FAULT)
            w_state_nx = clr ? ACQ : FAULT;
        else if (w_agree)
            w_state_nx = TRACK;
        else
            w_state_nx = (w_dis_nx >= DIS_MAX) ? FAULT : DISAGREE;
    end

    // synchronizers, state register, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            {r_a1, r_b1, r_sa, r_sb, r_cand} <= '0;
            r_state  <= ACQ;
            r_stab   <= '0;
            r_dis    <= '0;
            data_out <= 1'b0;
            valid    <= 1'b0;
            changed  <= 1'b0;
            fault    <= 1'b0;
            err_cnt  <= '0;
        end else begin
            r_a1    <= rail_a;
            r_b1    <= rail_b;
            r_sa    <= r_a1;
            r_sb    <= r_b1;
            r_state <= w_state_nx;
            r_dis   <= (w_state_nx == DISAGREE) ? w_dis_nx : '0;
            if (w_live) begin
                r_stab <= w_stab_nx;
                if (w_agree) r_cand <= r_sa;
            end else if (clr) begin
                r_stab <= '0;
            end
            if (w_commit) data_out <= ~r_sa;
            changed <= w_commit && (r_state == ACQ || data_out == r_sa);
            valid   <= w_state_nx == TRACK || w_state_nx == DISAGREE;
            fault   <= w_state_nx == FAULT;
            err_cnt <= clr ? '0 : (w_episode && !(&err_cnt)) ? err_cnt + CNT_W'(1) : err_cnt;
        end
    end
endmodule

// File: doc/dnot_rail_checker.md
Name: dnot_rail_checker

Overview:
- Receiving end of the redundant inverted-rail pair produced by the dual-NOT path: two copies of one signal, each passed through its own inverter.
- Synchronizes both rails, requires them to agree and stay stable before accepting a value, and outputs the recovered (re-inverted) bit.
- Counts disagreement episodes and raises a sticky fault when a disagreement persists.
- Sits between the dual-NOT output pins and downstream logic.

Parameters:
STABLE_CYCLES, 4, consecutive identical agreeing samples required before committing a value (>=1)
FAULT_CYCLES, 8, consecutive disagreeing samples that trigger fault (>=1)
CNT_W, 8, width of err_cnt

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
rail_a  in  1  inverted copy A (asynchronous)
rail_b  in  1  inverted copy B (asynchronous)
clr  in  1  clears fault and err_cnt; restarts acquisition when in FAULT
data_out  out  1  recovered bit = ~committed rail value
valid  out  1  data_out holds an accepted value
changed  out  1  one-cycle pulse on each commit
fault  out  1  sticky persistent-disagreement flag
err_cnt  out  CNT_W  saturating count of disagreement episodes

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: sync FFs 0, data_out 0, valid 0, changed 0, fault 0, err_cnt 0, stab_cnt 0, dis_cnt 0, state ACQ.
- rst asserted mid-operation forces all reset values at the next edge, regardless of clr or rails.
- Synchronizer: two FFs per rail. s_a and s_b are the second stages. agree = (s_a == s_b).
- Evaluation happens once per edge on s_a and s_b.
- Stability counting:
  - candidate is the last agreeing s_a.
  - stab_cnt increments while agree and s_a == candidate.
  - stab_cnt reloads to 1 on agree with a new value.
  - stab_cnt clears to 0 on disagree.
  - Commit occurs on the edge where the STABLE_CYCLES-th consecutive sample is seen: data_out <= ~candidate.
- changed pulses for one cycle when a commit changes data_out or moves ACQ->TRACK. It does not pulse on re-confirmation of the same value in TRACK.
- Latency: rails settle before edge E; commit (data_out, changed) is visible after edge E+STABLE_CYCLES+1.
- States:
  - ACQ: valid=0. Commit -> TRACK.
  - TRACK: valid=1. First disagreeing sample -> DISAGREE and err_cnt+1 (saturating at all-ones).
  - DISAGREE: valid=1, data_out held, dis_cnt counts consecutive disagreeing samples.
    - Agree sample -> TRACK with dis_cnt=0; stability restarts.
    - dis_cnt reaches FAULT_CYCLES -> FAULT with fault=1.
    - Fault timing: disagreement before edge E gives err_cnt+1 after E+2 and fault after E+FAULT_CYCLES+1.
  - FAULT: valid=0, data_out held, fault=1.
    - Ignores rails except for synchronization.
    - clr -> ACQ: fault=0, err_cnt=0, stab_cnt=0.
- A disagreement in ACQ does not increment err_cnt and does not fault; it only clears stab_cnt.
- clr in ACQ, TRACK or DISAGREE: err_cnt=0 and fault=0; the state is otherwise unaffected.
- clr in the same cycle as an episode start: clr wins, so err_cnt=0 and the episode is not counted.
- err_cnt holds at 2^CNT_W-1 when saturated.
- Counters are sized clog2(max+1).
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. Reset, rails held 0, STABLE_CYCLES=4 -> valid=1, data_out=1, changed=1 for one cycle after the 5th edge past rst release; err_cnt=0.
2. From TRACK data_out=1, both rails step to 1 before edge E -> data_out=0 and changed pulse after edge E+5; valid stays 1 throughout.
3. rail_a glitches to 1 for 3 cycles while rail_b=0 -> err_cnt 0->1 after E+2; no fault; data_out unchanged; stability restarts; no changed pulse when the value is re-confirmed.
4. rail_a=1, rail_b=0 held 20 cycles -> err_cnt=1; fault=1 and valid=0 after E+9; data_out held; fault stays set after the rails re-agree.
5. In FAULT, pulse clr with rails agreeing at 0 -> fault=0, err_cnt=0, state ACQ; valid=1 again after STABLE_CYCLES samples.
6. CNT_W=2, 5 short disagreement episodes -> err_cnt saturates at 3. Then clr coincident with a new episode start -> err_cnt=0.
7. Assert rst mid-DISAGREE -> all outputs 0 next edge.
